// File: rtl/svm_resp_fifo_wr_intf_pkg.sv
// Shared constants and state type for the SVM response FIFO write interface.
// Result words are written back into the response data FIFO one slice at a time.
package svm_resp_fifo_wr_intf_pkg;

  localparam int unsigned ROM_FIFO_DATA_WIDTH     = 8;
  localparam int unsigned IEEE_32BIT              = 32;
  localparam int unsigned NUM_OF_FIFO_WR_PER_WORD = IEEE_32BIT / ROM_FIFO_DATA_WIDTH;
  localparam int unsigned WORD_CNT_WIDTH          = 16;
  localparam int unsigned SLICE_CNT_WIDTH         = $clog2(NUM_OF_FIFO_WR_PER_WORD);

  localparam logic [SLICE_CNT_WIDTH-1:0] LAST_SLICE =
      SLICE_CNT_WIDTH'(NUM_OF_FIFO_WR_PER_WORD - 1);

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    PUSH_SLICES = 2'd1,
    WR_DONE     = 2'd2
  } t_svm_resp_fifo_wr_st;

endpackage

// File: rtl/svm_resp_fifo_wr_intf.sv
// Takes 32-bit result words from svm_core and pushes them MSB slice first into the
// response data FIFO, stalling on fifo_full and pulsing resp_wr_cmpltd per word.
module svm_resp_fifo_wr_intf
  import svm_resp_fifo_wr_intf_pkg::*;
(
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           resp_vld,
  input  logic [IEEE_32BIT-1:0]          resp_data,
  output logic                           resp_ready,
  output logic                           resp_wr_cmpltd,
  output logic                           resp_fifo_data_push,
  output logic [ROM_FIFO_DATA_WIDTH-1:0] resp_fifo_data_in,
  input  logic                           resp_fifo_full,
  input  logic                           resp_fifo_empty,
  output logic [WORD_CNT_WIDTH-1:0]      words_sent,
  output logic                           resp_drained,
  output logic                           protocol_err
);

  t_svm_resp_fifo_wr_st        state_q, state_d;
  logic [IEEE_32BIT-1:0]       word_q, word_d;
  logic [SLICE_CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic [WORD_CNT_WIDTH-1:0]   words_sent_q, words_sent_d;
  logic                        perr_q, perr_d;
  logic [IEEE_32BIT-1:0]       word_shifted;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      word_q       <= '0;
      cnt_q        <= '0;
      words_sent_q <= '0;
      perr_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      word_q       <= word_d;
      cnt_q        <= cnt_d;
      words_sent_q <= words_sent_d;
      perr_q       <= perr_d;
    end
  end

  assign resp_ready = (state_q == IDLE);

  // Slice select is purely a function of held state, so data stays put across stalls.
  assign word_shifted      = word_q << (32'(cnt_q) * ROM_FIFO_DATA_WIDTH);
  assign resp_fifo_data_in = word_shifted[IEEE_32BIT-1 -: ROM_FIFO_DATA_WIDTH];

  always_comb begin
    state_d             = state_q;
    word_d              = word_q;
    cnt_d               = cnt_q;
    words_sent_d        = words_sent_q;
    perr_d              = perr_q | (resp_vld & ~resp_ready);
    resp_fifo_data_push = 1'b0;
    resp_wr_cmpltd      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (resp_vld) begin
          word_d  = resp_data;
          cnt_d   = '0;
          state_d = PUSH_SLICES;
        end
      end
      PUSH_SLICES: begin
        resp_fifo_data_push = ~resp_fifo_full;
        if (!resp_fifo_full) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST_SLICE) begin
            state_d = WR_DONE;
          end
        end
      end
      WR_DONE: begin
        resp_wr_cmpltd = 1'b1;
        words_sent_d   = words_sent_q + 1'b1;
        state_d        = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign words_sent   = words_sent_q;
  assign protocol_err = perr_q;
  assign resp_drained = resp_ready & resp_fifo_empty;

endmodule
